// File: rtl/pwd_pkg.sv
// pwd_pkg: definitions shared by the password serializer and its FIFO.
//   PWD_WIDTH   - default number of bits per password code
//   PWD_DEPTH   - default number of FIFO entries
//   pwd_state_e - serializer state: IDLE (nothing shifting) or SHIFT
package pwd_pkg;

    localparam int PWD_WIDTH = 4;
    localparam int PWD_DEPTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pwd_state_e;

endpackage : pwd_pkg

// File: rtl/pwd_fifo.sv
// pwd_fifo: small synchronous FIFO holding password codes.
//   clk      - clock, all updates on the rising edge
//   reset    - asynchronous active-low reset, empties the FIFO
//   i_push   - request to write i_data (ignored while full or during i_clear)
//   i_data   - code to write
//   i_pop    - request to drop the head entry (ignored while empty or during i_clear)
//   i_clear  - synchronous flush, has priority over push and pop
//   o_head   - entry at the head of the FIFO (valid when !o_empty)
//   o_full   - FIFO holds DEPTH entries
//   o_empty  - FIFO holds no entries
//   o_count  - number of stored entries
module pwd_fifo
    import pwd_pkg::*;
#(
    parameter int WIDTH = PWD_WIDTH,
    parameter int DEPTH = PWD_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [FCNT_W-1:0] r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_pop_ok;

    // The count carries one extra bit so that full (DEPTH) and empty (0) differ.
    assign w_full    = (r_count == FCNT_W'(DEPTH));
    assign w_empty   = (r_count == FCNT_W'(0));
    // A push into a full FIFO is refused even if a pop frees a slot on the same edge.
    assign w_push_ok = i_push && !w_full && !i_clear;
    assign w_pop_ok  = i_pop && !w_empty && !i_clear;

    assign o_head  = r_mem[r_head];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= FCNT_W'(0);
        end else if (i_clear) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= FCNT_W'(0);
        end else begin
            if (w_push_ok) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, written at the tail on every accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push_ok) begin
            r_mem[r_tail] <= i_data;
        end
    end

endmodule : pwd_fifo

// File: rtl/password_serializer.sv
// password_serializer: buffers password codes and shifts them out MSB-first,
// one bit per clock, with no gap between consecutive codes.
//   clk         - clock, all updates on the rising edge
//   reset       - asynchronous active-low reset
//   in_code     - code offered for buffering
//   in_valid    - in_code is offered this cycle
//   in_ready    - FIFO can accept this cycle (not full)
//   clear       - synchronous flush of the FIFO and any frame in flight
//   data        - serial code bit (registered)
//   bit_valid   - data carries a code bit (registered)
//   frame_start - data is the MSB of a code (registered)
//   busy        - a frame is shifting or the FIFO holds codes
module password_serializer
    import pwd_pkg::*;
#(
    parameter int WIDTH = PWD_WIDTH,
    parameter int DEPTH = PWD_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             data,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    pwd_state_e         r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_data;
    logic               r_bit_valid;
    logic               r_frame_start;

    logic [WIDTH-1:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic [FCNT_W-1:0]  w_count;
    logic               w_pop;

    pwd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid),
        .i_data  (in_code),
        .i_pop   (w_pop),
        .i_clear (clear),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Pop the head whenever the shifter is free: idle, or emitting its last bit.
    always_comb begin
        w_pop = 1'b0;
        if (!clear && !w_empty &&
            ((r_state == IDLE) || (r_bit_cnt == CNT_W'(0)))) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    assign in_ready    = !w_full;
    assign busy        = (r_state == SHIFT) || (w_count != FCNT_W'(0));
    assign data        = r_data;
    assign bit_valid   = r_bit_valid;
    assign frame_start = r_frame_start;

    // Serializer FSM: the output bit is registered directly from the head on
    // load, and r_shift keeps only the bits still to be sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_shift       <= {WIDTH{1'b0}};
            r_bit_cnt     <= CNT_W'(0);
            r_data        <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (clear) begin
            r_state       <= IDLE;
            r_shift       <= {WIDTH{1'b0}};
            r_bit_cnt     <= CNT_W'(0);
            r_data        <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            case (r_state)
                SHIFT: begin
                    if (r_bit_cnt != CNT_W'(0)) begin
                        r_data        <= r_shift[WIDTH-1];
                        r_shift       <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_cnt     <= r_bit_cnt - CNT_W'(1);
                        r_bit_valid   <= 1'b1;
                        r_frame_start <= 1'b0;
                    end else if (!w_empty) begin
                        // Zero-bubble reload of the next code.
                        r_data        <= w_head[WIDTH-1];
                        r_shift       <= {w_head[WIDTH-2:0], 1'b0};
                        r_bit_cnt     <= CNT_W'(WIDTH - 1);
                        r_bit_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_state       <= IDLE;
                        r_shift       <= {WIDTH{1'b0}};
                        r_data        <= 1'b0;
                        r_bit_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                    end
                end
                IDLE: begin
                    if (!w_empty) begin
                        r_state       <= SHIFT;
                        r_data        <= w_head[WIDTH-1];
                        r_shift       <= {w_head[WIDTH-2:0], 1'b0};
                        r_bit_cnt     <= CNT_W'(WIDTH - 1);
                        r_bit_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_data        <= 1'b0;
                        r_bit_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_shift       <= {WIDTH{1'b0}};
                    r_bit_cnt     <= CNT_W'(0);
                    r_data        <= 1'b0;
                    r_bit_valid   <= 1'b0;
                    r_frame_start <= 1'b0;
                end
            endcase
        end
    end

endmodule : password_serializer
